xform_decode_stream: RTL and testbench
======================================

// Module: xform_decode_stream
// PURPOSE
//  Inverse of the 20->10 bit field transform: rebuilds the source word from an encoded result word plus key bits.
//   - Transform: out[1:0] = in[2:1] ^ in[4:3]; out[5:2] = ~in[8:5].
//   - Key bits: in[4:3], carried beside each encoded word.
//  Accepts a valid/ready stream, decodes each word, buffers it in a small FIFO and emits decoded words on a valid/ready stream.
//  Sits between the result capture path and the vector checker.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of 2, >=2
//  CNT_W    16  width of the accepted-word counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  s_valid    in   1      encoded word valid
//  s_ready    out  1      block can accept a word
//  s_enc      in   10     encoded word, same layout as the transform output
//  s_key      in   2      key bits = original in[4:3]
//  m_valid    out  1      decoded word available
//  m_ready    in   1      downstream accepts the decoded word
//  m_dec      out  20     reconstructed word
//  fill       out  $clog2(DEPTH)+1  current FIFO occupancy
//  word_cnt   out  CNT_W  words accepted since reset
//  fmt_err    out  1      sticky: an accepted word had s_enc[9:6] != 0
//  clr_err    in   1      synchronous clear of fmt_err
// BEHAVIOUR
//  Reset values (async, immediate): s_ready=1, m_valid=0, m_dec=0, fill=0, word_cnt=0, fmt_err=0, FIFO pointers=0.
//  Decode (combinational, on s_enc/s_key):
//   - d[2:1] = s_enc[1:0] ^ s_key.
//   - d[4:3] = s_key.
//   - d[8:5] = ~s_enc[5:2].
//   - d[0] = 0 and d[19:9] = 0. These bits are not recoverable.
//  Accept: s_valid && s_ready at a rising edge.
//   - d is written at the write pointer; fill and word_cnt each increment by 1.
//   - If s_enc[9:6] != 0 at the accept, fmt_err is set. The word is still stored.
//  Pop: m_valid && m_ready at a rising edge; the read pointer advances and fill decrements.
//  Outputs:
//   - s_ready = (fill != DEPTH). Combinational and registered-state based. When full, s_ready stays 0 even if a pop occurs that cycle.
//   - m_valid = (fill != 0). m_dec = entry at the read pointer; it holds stable while m_valid && !m_ready.
//   - Latency: a word accepted at edge N into an empty FIFO is presented with m_valid=1 after edge N. There is no combinational bypass.
//  Simultaneous push and pop (0 < fill < DEPTH): both happen, fill unchanged, order preserved.
//  Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. word_cnt wraps from 2^CNT_W-1 to 0 silently.
//  clr_err: at a clock edge with clr_err=1, fmt_err becomes 0. If a bad word is accepted at the same edge, set wins and fmt_err=1.
//  Reset mid-stream: all buffered words are discarded; nothing is emitted until new words are accepted.
//  s_enc and s_key are ignored whenever s_valid=0 or s_ready=0.
// STRUCTURE
//  Shared package xform_pkg:
//   - Constants: SRC_W=20, ENC_W=10.
//   - Field localparams: XOR_LO=1, KEY_LO=3, INV_LO=5, INV_W=4, ENC_INV_LO=2.
//   - Function xform_decode(enc, key).
//  One sub-module: xform_sync_fifo #(WIDTH, DEPTH). Holds the storage, pointers and fill; async active-high rst.
//  The top level holds the decode, word_cnt and fmt_err logic.
// TESTING
//  1. Single word: enc=10'h00D, key=2'b10, m_ready=1 -> one cycle later m_valid=1, m_dec=20'h00196; word_cnt=1.
//  2. Fill: m_ready=0, push 4 words -> fill=4, s_ready=0. A 5th s_valid is ignored; word_cnt stays 4.
//     Then m_ready=1 -> the 4 words drain in order, then m_valid=0.
//  3. Streaming: fill=2, s_valid=1 and m_ready=1 held for 10 cycles -> fill stays 2 and 10 words pass in order.
//  4. Format error: enc=10'h040 accepted -> fmt_err=1; m_dec=20'h001E0 (key=0).
//     clr_err pulse -> fmt_err=0. clr_err at the same edge as a bad accept -> fmt_err=1.
//  5. Reset mid-stream: fill=3, rst pulsed between edges -> m_valid=0, fill=0, word_cnt=0 immediately, before the next edge.
//  6. Wrap: CNT_W=4, accept 17 words -> word_cnt=1. With DEPTH=4, pointer wrap keeps data order intact.

Source files
------------

// File: rtl/xform_pkg.sv
// Shared field layout and decode function for the 20->10 bit field transform.
// The decode rebuilds the recoverable source bits; bit 0 and bits 19:9 are lost in the forward transform.
package xform_pkg;

   localparam int SRC_W      = 20;
   localparam int ENC_W      = 10;
   localparam int KEY_W      = 2;

   localparam int XOR_LO     = 1;
   localparam int KEY_LO     = 3;
   localparam int INV_LO     = 5;
   localparam int INV_W      = 4;
   localparam int ENC_INV_LO = 2;

   // Encoded bits above the inverted field must be zero in a well-formed word.
   localparam int ENC_CHK_LO = ENC_INV_LO + INV_W;
   localparam int ENC_CHK_W  = ENC_W - ENC_CHK_LO;

   function automatic logic [SRC_W-1:0] xform_decode(input logic [ENC_W-1:0] enc,
                                                      input logic [KEY_W-1:0] key);
      logic [SRC_W-1:0] d;
      d                   = '0;
      d[XOR_LO +: KEY_W]  = enc[KEY_W-1:0] ^ key;
      d[KEY_LO +: KEY_W]  = key;
      d[INV_LO +: INV_W]  = ~enc[ENC_INV_LO +: INV_W];
      return d;
   endfunction

   function automatic logic enc_fmt_bad(input logic [ENC_W-1:0] enc);
      return |enc[ENC_CHK_LO +: ENC_CHK_W];
   endfunction

endpackage

// File: rtl/xform_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the entry at the read pointer, zero when empty.
// Push is refused when full and pop when empty, even if requested.
module xform_sync_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   fill_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q,   fill_d;
   logic              do_push, do_pop;

   assign full_o  = (fill_q == FILL_W'(DEPTH));
   assign empty_o = (fill_q == '0);
   assign fill_o  = fill_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Gating keeps the output at zero while empty, so the unreset storage never leaks out.
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; pointers and fill define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/xform_decode_stream.sv
// Decodes encoded result words with their key bits and buffers them between two valid/ready streams.
// Also counts accepted words and flags any accepted word with non-zero unused encoded bits.
module xform_decode_stream
   import xform_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [ENC_W-1:0]       s_enc,
   input  logic [KEY_W-1:0]       s_key,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [SRC_W-1:0]       m_dec,
   output logic [$clog2(DEPTH):0] fill,
   output logic [CNT_W-1:0]       word_cnt,
   output logic                   fmt_err,
   input  logic                   clr_err
);

   logic             full, empty;
   logic             accept, pop;
   logic [SRC_W-1:0] dec_word;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             fmt_err_q,  fmt_err_d;

   assign s_ready  = !full;
   assign m_valid  = !empty;
   assign accept   = s_valid && s_ready;
   assign pop      = m_valid && m_ready;
   assign dec_word = xform_decode(s_enc, s_key);

   xform_sync_fifo #(
      .WIDTH (SRC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (accept),
      .wr_data_i (dec_word),
      .pop_i     (pop),
      .rd_data_o (m_dec),
      .full_o    (full),
      .empty_o   (empty),
      .fill_o    (fill)
   );

   // A bad accept on the same edge as clr_err leaves the flag set.
   always_comb begin
      word_cnt_d = accept ? word_cnt_q + 1'b1 : word_cnt_q;
      fmt_err_d  = (fmt_err_q && !clr_err) || (accept && enc_fmt_bad(s_enc));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt_q <= '0;
         fmt_err_q  <= 1'b0;
      end else begin
         word_cnt_q <= word_cnt_d;
         fmt_err_q  <= fmt_err_d;
      end
   end

   assign word_cnt = word_cnt_q;
   assign fmt_err  = fmt_err_q;

endmodule

// File: tb/tb_xform_decode_stream.sv
// Directed bench for xform_decode_stream: reset, decode, fill/drain, streaming, format error, reset, wrap.
module tb_xform_decode_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, m_ready, clr_err;
   logic [9:0]  s_enc;
   logic [1:0]  s_key;
   logic        s_ready, m_valid, fmt_err;
   logic [19:0] m_dec;
   logic [2:0]  fill;
   logic [15:0] word_cnt;

   // Narrow-counter instance for the wrap scenario.
   logic        w_valid, w_mready;
   logic [9:0]  w_enc;
   logic [1:0]  w_key;
   logic        w_sready, w_mvalid, w_err;
   logic [19:0] w_dec;
   logic [2:0]  w_fill;
   logic [3:0]  w_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [19:0] mq[$];
   logic [15:0] m_cnt;
   logic        m_err;

   always #5 clk = ~clk;

   xform_decode_stream #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_enc(s_enc), .s_key(s_key),
      .m_valid(m_valid), .m_ready(m_ready), .m_dec(m_dec), .fill(fill), .word_cnt(word_cnt),
      .fmt_err(fmt_err), .clr_err(clr_err)
   );

   xform_decode_stream #(.DEPTH(4), .CNT_W(4)) dut_w (
      .clk(clk), .rst(rst), .s_valid(w_valid), .s_ready(w_sready), .s_enc(w_enc), .s_key(w_key),
      .m_valid(w_mvalid), .m_ready(w_mready), .m_dec(w_dec), .fill(w_fill), .word_cnt(w_cnt),
      .fmt_err(w_err), .clr_err(1'b0)
   );

   function automatic logic [19:0] model_dec(input logic [9:0] e, input logic [1:0] k);
      return {11'b0, ~e[5:2], k, e[1:0] ^ k, 1'b0};
   endfunction

   // Advance one edge, updating the bench model from the inputs being driven.
   task automatic tick();
      logic acc, pp, bad;
      acc = s_valid && (mq.size() != 4);
      pp  = m_ready && (mq.size() != 0);
      bad = |s_enc[9:6];
      @(posedge clk);
      if (pp) void'(mq.pop_front());
      if (acc) begin
         mq.push_back(model_dec(s_enc, s_key));
         m_cnt = m_cnt + 16'd1;
      end
      m_err = (m_err && !clr_err) || (acc && bad);
      #1;
   endtask

   task automatic drain();
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_vec++;
      if ({s_ready, m_valid} !== 2'b10) begin
         $display("FAIL reset_hs: s_ready/m_valid=%b expected 10", {s_ready, m_valid}); n_err++;
      end
      n_vec++;
      if (m_dec !== 20'h0 || fill !== 3'd0) begin
         $display("FAIL reset_data: m_dec=%h fill=%0d expected 0/0", m_dec, fill); n_err++;
      end
      n_vec++;
      if (word_cnt !== 16'd0 || fmt_err !== 1'b0) begin
         $display("FAIL reset_cnt: word_cnt=%0d fmt_err=%b expected 0/0", word_cnt, fmt_err); n_err++;
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      s_valid = 1'b1; s_enc = 10'h00D; s_key = 2'b10; m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      n_vec++;
      if (m_valid !== 1'b1 || m_dec !== 20'h00196) begin
         $display("FAIL single_dec: m_valid=%b m_dec=%h expected 1/00196", m_valid, m_dec); n_err++;
      end
      n_vec++;
      if (word_cnt !== 16'd1) begin
         $display("FAIL single_cnt: word_cnt=%0d expected 1", word_cnt); n_err++;
      end
      tick();
      n_vec++;
      if (m_valid !== 1'b0) begin
         $display("FAIL single_pop: m_valid=%b expected 0", m_valid); n_err++;
      end
      m_ready = 1'b0;
   endtask

   task automatic test_fill();
      logic [19:0] exp_w [4];
      logic [9:0]  encs [4] = '{10'h03F, 10'h001, 10'h02A, 10'h015};
      logic [1:0]  keys [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_enc = encs[i]; s_key = keys[i];
         exp_w[i] = model_dec(encs[i], keys[i]);
         tick();
      end
      n_vec++;
      if (fill !== 3'd4 || s_ready !== 1'b0) begin
         $display("FAIL fill_full: fill=%0d s_ready=%b expected 4/0", fill, s_ready); n_err++;
      end
      s_enc = 10'h3FF; s_key = 2'b11;
      tick();
      s_valid = 1'b0;
      n_vec++;
      if (word_cnt !== 16'd5 || fill !== 3'd4) begin
         $display("FAIL fill_ignore: word_cnt=%0d fill=%0d expected 5/4", word_cnt, fill); n_err++;
      end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (m_valid !== 1'b1 || m_dec !== exp_w[i]) begin
            $display("FAIL fill_drain%0d: m_valid=%b m_dec=%h expected 1/%h", i, m_valid, m_dec, exp_w[i]);
            n_err++;
         end
         tick();
      end
      n_vec++;
      if (m_valid !== 1'b0 || fmt_err !== 1'b0) begin
         $display("FAIL fill_empty: m_valid=%b fmt_err=%b expected 0/0", m_valid, fmt_err); n_err++;
      end
      m_ready = 1'b0;
   endtask

   task automatic test_streaming();
      m_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1; s_enc = 10'(i * 11 + 3); s_key = 2'(i);
         tick();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_enc = 10'((i * 37 + 5) & 'h3F); s_key = 2'(i + 1);
         n_vec++;
         if (fill !== 3'd2 || m_valid !== 1'b1 || m_dec !== mq[0]) begin
            $display("FAIL stream%0d: fill=%0d m_dec=%h expected 2/%h", i, fill, m_dec, mq[0]); n_err++;
         end
         tick();
      end
      s_valid = 1'b0;
      while (mq.size() != 0) begin
         n_vec++;
         if (m_dec !== mq[0]) begin
            $display("FAIL stream_tail: m_dec=%h expected %h", m_dec, mq[0]); n_err++;
         end
         tick();
      end
      n_vec++;
      if (m_valid !== 1'b0 || word_cnt !== m_cnt) begin
         $display("FAIL stream_end: m_valid=%b word_cnt=%0d expected 0/%0d", m_valid, word_cnt, m_cnt); n_err++;
      end
      m_ready = 1'b0;
   endtask

   task automatic test_fmt_err();
      s_valid = 1'b1; s_enc = 10'h040; s_key = 2'b00; m_ready = 1'b0;
      tick();
      s_valid = 1'b0;
      n_vec++;
      if (fmt_err !== 1'b1 || m_dec !== 20'h001E0) begin
         $display("FAIL fmt_set: fmt_err=%b m_dec=%h expected 1/001E0", fmt_err, m_dec); n_err++;
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      n_vec++;
      if (fmt_err !== 1'b0) begin
         $display("FAIL fmt_clr: fmt_err=%b expected 0", fmt_err); n_err++;
      end
      s_valid = 1'b1; s_enc = 10'h200; s_key = 2'b01; clr_err = 1'b1;
      tick();
      s_valid = 1'b0; clr_err = 1'b0;
      n_vec++;
      if (fmt_err !== 1'b1 || fill !== 3'd2) begin
         $display("FAIL fmt_setwins: fmt_err=%b fill=%0d expected 1/2", fmt_err, fill); n_err++;
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_enc = 10'(i + 1); s_key = 2'(i);
         tick();
      end
      s_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (m_valid !== 1'b0 || fill !== 3'd0 || word_cnt !== 16'd0) begin
         $display("FAIL rst_mid: m_valid=%b fill=%0d word_cnt=%0d expected 0/0/0", m_valid, fill, word_cnt);
         n_err++;
      end
      mq.delete(); m_cnt = '0; m_err = 1'b0;
      #1 rst = 1'b0;
      m_ready = 1'b1;
      tick();
      n_vec++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         $display("FAIL rst_after: m_valid=%b s_ready=%b expected 0/1", m_valid, s_ready); n_err++;
      end
      m_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [19:0] prev;
      w_mready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         w_valid = 1'b1; w_enc = 10'((i * 13 + 7) & 'h3F); w_key = 2'(i * 3);
         @(posedge clk); #1;
         prev = model_dec(10'((i * 13 + 7) & 'h3F), 2'(i * 3));
         n_vec++;
         if (w_mvalid !== 1'b1 || w_dec !== prev) begin
            $display("FAIL wrap_data%0d: m_dec=%h expected %h", i, w_dec, prev); n_err++;
         end
      end
      w_valid = 1'b0;
      n_vec++;
      if (w_cnt !== 4'd1) begin
         $display("FAIL wrap_cnt: word_cnt=%0d expected 1", w_cnt); n_err++;
      end
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; clr_err = 1'b0; s_enc = '0; s_key = '0;
      w_valid = 1'b0; w_mready = 1'b0; w_enc = '0; w_key = '0;
      m_cnt = '0; m_err = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_streaming();
      test_fmt_err();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
